if_fetch: RTL and testbench

//  Instruction-fetch stage: owns the PC, reads each 32-bit instruction as four bytes over the

---
 rtl/if_fetch.sv | 146 ++++++++++++++
 tb/tb_if_fetch.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, assembles each 32-bit instruction from four
// little-endian byte reads on the shared 8-bit memory port, and presents if_pc/if_inst
// to if_id. Branch redirects from EX (older) take priority over ID.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic        id_b_flag_i,
  input  logic [31:0] id_b_target_i,
  input  logic        ex_b_flag_i,
  input  logic [31:0] ex_b_target_i,
  input  logic        mem_busy_i,
  input  logic [7:0]  mem_din_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        stallreq_o
);

  localparam int unsigned XLEN    = 32;
  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned STALL_W = 6;
  localparam int unsigned CNT_W   = 3;
  localparam int unsigned GOT_W   = 2;
  localparam int unsigned BUF_W   = 3 * BYTE_W;
  localparam logic        STOP    = 1'b1;
  localparam logic [CNT_W-1:0] NBYTES = CNT_W'(4);

  typedef enum logic {
    S_FETCH = 1'b0,
    S_READY = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [XLEN-1:0]    pc_q, pc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [GOT_W-1:0]   got_q, got_d;
  logic               pend_q, pend_d;
  logic [BUF_W-1:0]   buf_q, buf_d;
  logic               req_q, req_d;
  logic [XLEN-1:0]    addr_q, addr_d;
  logic [XLEN-1:0]    if_pc_q;
  logic [XLEN-1:0]    if_inst_q, inst_d;
  logic               stallreq_q, stallreq_d;
  logic               accept;
  logic               unused_stall;

  // Only the PC-hold and IF-hold bits of the stall vector matter here
  assign unused_stall = ^stall[STALL_W-1:2];

  // Request handshake: the port took our byte read this cycle
  assign accept = req_q & ~mem_busy_i;

  // Next-state logic; redirects override everything, then the FETCH/READY behaviour
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    got_d   = got_q;
    buf_d   = buf_q;
    inst_d  = '0;
    pend_d  = accept;

    if (ex_b_flag_i || id_b_flag_i) begin
      // Drop any partial fetch; the byte in flight is discarded via pend
      pc_d    = ex_b_flag_i ? ex_b_target_i : id_b_target_i;
      state_d = S_FETCH;
      cnt_d   = '0;
      got_d   = '0;
      pend_d  = 1'b0;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (accept) cnt_d = cnt_q + CNT_W'(1);
          if (pend_q) begin
            got_d = got_q + GOT_W'(1);
            case (got_q)
              2'd0:    buf_d[7:0]   = mem_din_i;
              2'd1:    buf_d[15:8]  = mem_din_i;
              2'd2:    buf_d[23:16] = mem_din_i;
              default: begin
                inst_d  = {mem_din_i, buf_q};
                state_d = S_READY;
              end
            endcase
          end
        end
        S_READY: begin
          inst_d = if_inst_q;
          if (stall[1] != STOP) begin
            // Word consumed by if_id; PC advances unless the PC itself is held
            state_d = S_FETCH;
            cnt_d   = '0;
            got_d   = '0;
            inst_d  = '0;
            if (stall[0] != STOP) pc_d = pc_q + XLEN'(4);
          end
        end
        default: state_d = S_FETCH;
      endcase
    end

    req_d      = (state_d == S_FETCH) && (cnt_d < NBYTES);
    addr_d     = pc_d + XLEN'(cnt_d);
    stallreq_d = (state_d == S_FETCH);
  end

  // State and registered outputs, synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_FETCH;
      pc_q       <= RESET_PC;
      cnt_q      <= '0;
      got_q      <= '0;
      pend_q     <= 1'b0;
      buf_q      <= '0;
      req_q      <= 1'b0;
      addr_q     <= '0;
      if_pc_q    <= RESET_PC;
      if_inst_q  <= '0;
      stallreq_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      cnt_q      <= cnt_d;
      got_q      <= got_d;
      pend_q     <= pend_d;
      buf_q      <= buf_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      if_pc_q    <= pc_d;
      if_inst_q  <= inst_d;
      stallreq_q <= stallreq_d;
    end
  end

  assign mem_req_o  = req_q;
  assign mem_addr_o = addr_q;
  assign if_pc      = if_pc_q;
  assign if_inst    = if_inst_q;
  assign stallreq_o = stallreq_q;

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: byte-memory model, expected-word scoreboard, immediate assertions.
module tb_if_fetch;

  logic        clk;
  logic        rst;
  logic [5:0]  stall;
  logic        id_b_flag_i;
  logic [31:0] id_b_target_i;
  logic        ex_b_flag_i;
  logic [31:0] ex_b_target_i;
  logic        mem_busy_i;
  logic [7:0]  mem_din_i = 8'h00;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        stallreq_o;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  if_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .id_b_flag_i   (id_b_flag_i),
    .id_b_target_i (id_b_target_i),
    .ex_b_flag_i   (ex_b_flag_i),
    .ex_b_target_i (ex_b_target_i),
    .mem_busy_i    (mem_busy_i),
    .mem_din_i     (mem_din_i),
    .mem_req_o     (mem_req_o),
    .mem_addr_o    (mem_addr_o),
    .if_pc         (if_pc),
    .if_inst       (if_inst),
    .stallreq_o    (stallreq_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Byte memory contents: fixed instruction at 0, address-derived pattern elsewhere
  function automatic logic [7:0] mbyte(input logic [31:0] a);
    case (a)
      32'd0:   mbyte = 8'h13;
      32'd1:   mbyte = 8'h05;
      32'd2:   mbyte = 8'h10;
      32'd3:   mbyte = 8'h00;
      default: mbyte = a[7:0] ^ a[15:8] ^ 8'h3C;
    endcase
  endfunction

  function automatic logic [31:0] word(input logic [31:0] pc);
    logic [31:0] w;
    for (int k = 0; k < 4; k++) w[8*k +: 8] = mbyte(pc + 32'(k));
    return w;
  endfunction

  // Memory port: accepted read returns data one cycle later, otherwise garbage
  always @(posedge clk) begin
    mem_din_i <= (mem_req_o && !mem_busy_i) ? mbyte(mem_addr_o) : 8'hEE;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic expect_fetch(input logic [31:0] pc);
    exp_t e;
    e.pc   = pc;
    e.inst = word(pc);
    exp_q.push_back(e);
  endtask

  // Issue n addresses of a fetch starting at pc, leaving the next one visible
  task automatic partial(input logic [31:0] pc, input int n);
    for (int k = 0; k < n; k++) begin
      check("partial_addr", mem_addr_o, pc + 32'(k));
      tick();
    end
  endtask

  // Full fetch from the first visible request to READY; optional busy on byte bi
  task automatic run_fetch(input logic [31:0] pc, input int bi, input int bn);
    exp_t e;
    check("inst_zero_in_fetch", if_inst, 32'h0);
    for (int k = 0; k < 4; k++) begin
      if (k == bi) begin
        for (int b = 0; b < bn; b++) begin
          mem_busy_i = 1'b1;
          check("busy_addr_hold", mem_addr_o, pc + 32'(k));
          tick();
        end
        mem_busy_i = 1'b0;
      end
      check("req", 32'(mem_req_o), 32'd1);
      check("addr", mem_addr_o, pc + 32'(k));
      tick();
    end
    check("req_off_last_byte", 32'(mem_req_o), 32'd0);
    check("stallreq_fetch", 32'(stallreq_o), 32'd1);
    tick();
    check("stallreq_ready", 32'(stallreq_o), 32'd0);
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $error("FAIL scoreboard_empty observed=READY expected=no_entry");
    end else begin
      e = exp_q.pop_front();
      check("if_pc", if_pc, e.pc);
      check("if_inst", if_inst, e.inst);
    end
  endtask

  initial begin
    rst = 1'b1; stall = 6'b0; mem_busy_i = 1'b0;
    id_b_flag_i = 1'b0; id_b_target_i = 32'h0;
    ex_b_flag_i = 1'b0; ex_b_target_i = 32'h0;
    tick(); tick();

    // Reset state
    check("rst_req", 32'(mem_req_o), 32'd0);
    check("rst_addr", mem_addr_o, 32'h0);
    check("rst_if_pc", if_pc, 32'h0);
    check("rst_if_inst", if_inst, 32'h0);
    check("rst_stallreq", 32'(stallreq_o), 32'd0);
    rst = 1'b0;
    tick();

    // 1: plain fetch at 0
    expect_fetch(32'h0);
    run_fetch(32'h0, -1, 0);
    check("t1_inst_const", if_inst, 32'h0010_0513);
    tick();

    // 2: busy for two cycles on byte 2
    expect_fetch(32'h4);
    run_fetch(32'h4, 2, 2);

    // 3: IF hold in READY keeps outputs, then consume
    stall = 6'b000010;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_req", 32'(mem_req_o), 32'd0);
      check("hold_inst", if_inst, word(32'h4));
      check("hold_pc", if_pc, 32'h4);
      check("hold_stallreq", 32'(stallreq_o), 32'd0);
    end
    stall = 6'b0;
    tick();
    check("after_hold_req", 32'(mem_req_o), 32'd1);
    check("after_hold_addr", mem_addr_o, 32'h8);

    // PC hold while consuming: same pc fetched again
    expect_fetch(32'h8);
    run_fetch(32'h8, -1, 0);
    stall = 6'b000001;
    tick();
    stall = 6'b0;
    check("pchold_addr", mem_addr_o, 32'h8);
    check("pchold_if_pc", if_pc, 32'h8);
    check("pchold_inst", if_inst, 32'h0);
    expect_fetch(32'h8);
    run_fetch(32'h8, -1, 0);
    tick();

    // 4: EX redirect with two bytes captured and one in flight
    partial(32'hC, 3);
    ex_b_flag_i = 1'b1; ex_b_target_i = 32'h100;
    tick();
    ex_b_flag_i = 1'b0;
    check("exr_addr", mem_addr_o, 32'h100);
    check("exr_req", 32'(mem_req_o), 32'd1);
    check("exr_if_pc", if_pc, 32'h100);
    check("exr_inst", if_inst, 32'h0);
    check("exr_stallreq", 32'(stallreq_o), 32'd1);
    expect_fetch(32'h100);
    run_fetch(32'h100, -1, 0);
    tick();

    // 5: EX wins over ID
    partial(32'h104, 1);
    id_b_flag_i = 1'b1; id_b_target_i = 32'h40;
    ex_b_flag_i = 1'b1; ex_b_target_i = 32'h80;
    tick();
    id_b_flag_i = 1'b0; ex_b_flag_i = 1'b0;
    check("prio_addr", mem_addr_o, 32'h80);
    check("prio_if_pc", if_pc, 32'h80);
    expect_fetch(32'h80);
    run_fetch(32'h80, -1, 0);

    // ID redirect applied despite IF hold; target fetch wraps the address space
    stall = 6'b000010;
    id_b_flag_i = 1'b1; id_b_target_i = 32'hFFFF_FFFE;
    tick();
    id_b_flag_i = 1'b0;
    stall = 6'b0;
    check("idr_addr", mem_addr_o, 32'hFFFF_FFFE);
    check("idr_inst", if_inst, 32'h0);
    check("idr_stallreq", 32'(stallreq_o), 32'd1);
    expect_fetch(32'hFFFF_FFFE);
    run_fetch(32'hFFFF_FFFE, -1, 0);
    tick();

    // 6: reset mid-fetch with cnt=3
    partial(32'h2, 3);
    rst = 1'b1;
    tick();
    check("mrst_req", 32'(mem_req_o), 32'd0);
    check("mrst_addr", mem_addr_o, 32'h0);
    check("mrst_if_pc", if_pc, 32'h0);
    check("mrst_inst", if_inst, 32'h0);
    check("mrst_stallreq", 32'(stallreq_o), 32'd0);
    rst = 1'b0;
    tick();
    expect_fetch(32'h0);
    run_fetch(32'h0, -1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
